vec_mem_reader: RTL
===================

# vec_mem_reader

Streaming read engine for the on-chip vector element memory. On a start command it walks `length` elements from `base_addr` with a fixed stride. It drives the RAM's asynchronous read address and presents each element on a valid/ready output stream toward the vector register file / lanes. It is the reading end of the RAM, complementing the write-side loaders.

## Interface
- `ADDR_WIDTH`, 8: RAM address width; must match the RAM instance.
- `DATA_WIDTH`, 8: element width.
- `LEN_WIDTH`, 9: width of `length`; allows 0..2^ADDR_WIDTH elements.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `start`  in  1: command pulse; accepted only when `busy`=0.
- `base_addr`  in  ADDR_WIDTH: first element address.
- `length`  in  LEN_WIDTH: element count.
- `stride`  in  ADDR_WIDTH: address increment per element.
- `busy`  out  1: high from accepted start until last element handed off.
- `done`  out  1: one-cycle pulse at command completion.
- `rd_addr`  out  ADDR_WIDTH: to RAM read address.
- `rd_data`  in  DATA_WIDTH: from RAM; combinational read of `rd_addr`.
- `out_valid`  out  1: output element valid.
- `out_ready`  in  1: consumer accepts.
- `out_data`  out  DATA_WIDTH: element.
- `out_last`  out  1: qualifies final element of the command.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 with `length`>0 → latch `addr`=`base_addr`, `remaining`=`length`, `stride`; go to RUN.
  - `start`=1 with `length`=0 → `done` pulses the next cycle; stay IDLE; no output.
- RUN:
  - `rd_addr`=`addr`.
  - Fetch condition: output register empty (`out_valid`=0), or output transfer occurring (`out_valid`&`out_ready`).
  - On fetch: `out_data`<=`rd_data`, `out_valid`<=1, `out_last`<=(`remaining`==1), `addr`<=`addr`+`stride` mod 2^ADDR_WIDTH (wraps silently), `remaining`--.
  - Fetch with `remaining`==1 → DRAIN.
- DRAIN: on `out_valid`&`out_ready` → `out_valid`<=0, `done`<=1, go to IDLE.
- Stall: `out_valid`=1 & `out_ready`=0 → `out_data`, `out_last`, `addr`, `remaining` held.
- `start` while `busy`=1 is ignored.
- `rd_addr` in IDLE/DRAIN = last `addr` value (don't-care to RAM).
- Same-cycle RAM write to the address being fetched: the pre-edge (old) value is captured.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `rd_addr`=0; state IDLE.
- Start sampled at edge E → RUN, `busy`=1 after E. First fetch at E+1; `out_valid`=1 after E+1.
- Throughput: one element per cycle with `out_ready` held high.
- With `out_ready`=1 continuously, `done` is high in the cycle following E+length+1. `busy` falls in the same cycle.
- A new `start` is accepted in the cycle `done` is high.
- `rst_n`=0 at any edge aborts the command. All outputs return to reset values; no `done`.

## Configuration
- `VEC_READER_STRIDE_EN` defined: `stride` port is present and used as described.
- Undefined: `stride` port is absent; increment is fixed at 1. All other behaviour is identical.

## Structure
- Shared package `vpu_mem_pkg`: state enum typedef (IDLE/RUN/DRAIN) and default width constants.
- No sub-module. The RAM is external; the bench instantiates `single_port_ram` and connects `rd_addr`/`rd_data`.

## Test plan
- RAM[i]=i+0x10. Start base=4, len=3, stride=1, `out_ready`=1 → out 0x14, 0x15, 0x16 on consecutive cycles; `out_last` on 0x16; one `done` pulse.
- Base=0xFE, len=4, stride=1 → addresses FE, FF, 00, 01; data 0x0E, 0x0F, 0x10, 0x11.
- Stride=3, base=0, len=3 (macro on) → 0x10, 0x13, 0x16. Macro off → 0x10, 0x11, 0x12.
- Len=5, `out_ready` toggling 1,0,0,1,… → every element delivered exactly once, in order; `out_data` stable during stalls.
- Len=0 → no `out_valid`; `done` one cycle after start. A `start` while busy is ignored.
- `rst_n` low mid-stream after 2 elements → all outputs 0 next cycle. A new start afterwards runs normally from its base.

Source files
------------

// File: rtl/vpu_mem_pkg.sv
// Shared definitions for the vector element memory blocks: reader FSM states
// and default width constants.
package vpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 9;

endpackage

// File: rtl/single_port_ram.sv
// Vector element RAM: synchronous write, combinational read of rd_addr.
module single_port_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vec_mem_reader.sv
// Strided streaming reader for the vector element RAM with a valid/ready output.
// VEC_READER_STRIDE_EN: adds the stride port; otherwise the increment is fixed at 1.
module vec_mem_reader
    import vpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
`ifdef VEC_READER_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [ADDR_WIDTH-1:0] step;
    logic                  fetch;
    logic                  accept;
    logic                  last_fetch;

`ifdef VEC_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;

    always_ff @(posedge clk) begin
        if (!rst_n)                        stride_q <= '0;
        else if (accept && length != '0)   stride_q <= stride;
    end

    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && length != '0) state_d = RUN;
            RUN:     if (last_fetch)            state_d = DRAIN;
            DRAIN:   if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Refill whenever the single output register is empty or being emptied this cycle.
    always_comb begin
        busy       = (state_q != IDLE);
        accept     = (state_q == IDLE) && start;
        fetch      = (state_q == RUN) && (!out_valid || out_ready);
        last_fetch = fetch && (remaining_q == LEN_WIDTH'(1));
        rd_addr    = addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (length != '0) begin
                    addr_q      <= base_addr;
                    remaining_q <= length;
                end else begin
                    done <= 1'b1;
                end
            end
            if (fetch) begin
                out_data    <= rd_data;
                out_valid   <= 1'b1;
                out_last    <= (remaining_q == LEN_WIDTH'(1));
                addr_q      <= addr_q + step;
                remaining_q <= remaining_q - LEN_WIDTH'(1);
            end else if (state_q == DRAIN && out_valid && out_ready) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule
